cart_backup_ctrl: RTL and testbench
===================================

CART_BACKUP_CTRL -- requirements
Module: cart_backup_ctrl

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 24'd12000000, meaning the clk_sys cycles to wait for sd_ack after a request before aborting.
REQ-002 SHALL have port clk_sys, input, 1, the single system clock.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port has_save, input, 1, meaning the cart has battery-backed RAM.
REQ-005 SHALL have port ram_mask_file, input, 8, meaning the last sector index (number of 512-byte sectors minus 1).
REQ-006 SHALL have port cart_download, input, 1, meaning a ROM download is in progress.
REQ-007 SHALL have port cram_wr, input, 1, meaning the CPU is writing cart RAM.
REQ-008 SHALL have port load_req, input, 1, level; a rising edge requests a load (SD to cart RAM).
REQ-009 SHALL have port save_req, input, 1, level; a rising edge requests a save (cart RAM to SD).
REQ-010 SHALL have port save_force, input, 1, meaning save even when the dirty flag is clear.
REQ-011 SHALL have port sd_lba, output, 32, the sector address.
REQ-012 SHALL have ports sd_rd and sd_wr, output, 1 each, the sector read and write requests.
REQ-013 SHALL have port sd_ack, input, 1, high while the host services the sector.
REQ-014 SHALL have ports sd_buff_addr (input, 8, word index), sd_buff_dout (input, 16), sd_buff_wr (input, 1) and sd_buff_din (output, 16).
REQ-015 SHALL have ports bk_addr (output, 17), bk_wr (output, 1), bk_data (output, 16) and bk_q (input, 16, valid one cycle after bk_addr).
REQ-016 SHALL have status outputs busy (1), done (1, single-cycle pulse), err (1, sticky until the next request) and dirty (1).

Function
REQ-017 SHALL implement the states IDLE, START, WAIT_ACK, XFER, NEXT and FINISH, plus a sector counter sector[7:0] and an op bit (0 = load, 1 = save).
REQ-018 SHALL detect load and save requests by registered rising edges; edges that arrive while busy or while cart_download=1 are discarded and not queued.
REQ-019 In IDLE, a load_req edge with has_save=1 SHALL set op=0, sector=0 and go to START.
REQ-020 In IDLE, a save_req edge with has_save=1 and (dirty or save_force) SHALL set op=1, sector=0, clear dirty and go to START.
REQ-021 If load and save edges arrive in the same cycle, the load SHALL win and the save SHALL be dropped.
REQ-022 START SHALL drive sd_lba={24'd0, sector}, assert sd_rd (load) or sd_wr (save), clear the timeout counter and go to WAIT_ACK.
REQ-023 WAIT_ACK SHALL hold the request until sd_ack=1, then deassert it in the same cycle and go to XFER.
REQ-024 If the timeout counter reaches ACK_TIMEOUT in WAIT_ACK, the block SHALL deassert the request, set err=1 and go to FINISH.
REQ-025 XFER SHALL stay while sd_ack=1 and go to NEXT on sd_ack=0.
REQ-026 NEXT SHALL go to FINISH when sector==ram_mask_file; otherwise it SHALL increment sector (8-bit, no wrap beyond the mask) and go to START.
REQ-027 FINISH SHALL pulse done for one cycle and return to IDLE; busy=1 in every state except IDLE.
REQ-028 bk_addr SHALL equal {1'b0, sector, sd_buff_addr} combinationally while busy, and 17'd0 otherwise.
REQ-029 bk_wr SHALL equal sd_buff_wr & (state==XFER) & (op==0), combinationally, with bk_data=sd_buff_dout.
REQ-030 sd_buff_din SHALL equal bk_q; the host reads one cycle after presenting sd_buff_addr.
REQ-031 The dirty flag SHALL be set by cram_wr whenever no load is active, including during a save.
REQ-032 The dirty flag SHALL be cleared at save start (REQ-020), at load FINISH and on a cart_download rising edge.
REQ-033 cart_download=1 in any non-IDLE state SHALL abort the operation: sd_rd/sd_wr deasserted next cycle, state to IDLE, no done pulse, err unchanged.
REQ-034 A new accepted request SHALL clear err.

Reset
REQ-035 reset_n=0 SHALL asynchronously force state IDLE, sector=0, sd_lba=0, sd_rd=0, sd_wr=0, busy=0, done=0, err=0, dirty=0 and clear the edge-detect registers, with bk_wr=0.
REQ-036 A reset mid-operation SHALL abandon the transfer without a done pulse; after release the block SHALL accept requests immediately.

Verification
REQ-037 Load with ram_mask_file=8'h0F and an ideal host: 16 sectors with sd_lba 0..15, 256 bk_wr per sector, the last write at bk_addr=17'h0FFF, then a single done and dirty=0.
REQ-038 Save with dirty=0 and save_force=0: no sd_wr and busy stays 0. After one cram_wr, a save produces 16 sd_wr requests, with sd_buff_din matching the preloaded bk_q pattern on sd_buff_addr+sector.
REQ-039 Simultaneous load_req and save_req edges: op=load, and no sd_wr asserts during the operation.
REQ-040 Host never acks, with ACK_TIMEOUT reduced to 100: sd_rd drops at cycle 100 after START, err=1, one done pulse, then IDLE.
REQ-041 cart_download rises during the XFER of sector 3: IDLE next cycle, no done, dirty=0.
REQ-042 reset_n pulsed low during WAIT_ACK: all outputs at reset values immediately, and a new load succeeds afterwards.

Source files
------------

// File: rtl/cart_backup_ctrl.sv
// rtl/cart_backup_ctrl.sv - cartridge battery RAM backup/restore sequencer over an SD sector host
// Walks sectors 0..ram_mask_file, streaming each 512-byte sector between the SD buffer and cart RAM.
module cart_backup_ctrl #(
   parameter logic [23:0] ACK_TIMEOUT = 24'd12000000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        has_save,
   input  logic [7:0]  ram_mask_file,
   input  logic        cart_download,
   input  logic        cram_wr,
   input  logic        load_req,
   input  logic        save_req,
   input  logic        save_force,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   input  logic        sd_ack,
   input  logic [7:0]  sd_buff_addr,
   input  logic [15:0] sd_buff_dout,
   input  logic        sd_buff_wr,
   output logic [15:0] sd_buff_din,
   output logic [16:0] bk_addr,
   output logic        bk_wr,
   output logic [15:0] bk_data,
   input  logic [15:0] bk_q,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        dirty
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_START    = 3'd1;
   localparam logic [2:0] S_WAIT_ACK = 3'd2;
   localparam logic [2:0] S_XFER     = 3'd3;
   localparam logic [2:0] S_NEXT     = 3'd4;
   localparam logic [2:0] S_FINISH   = 3'd5;

   logic [2:0]  state;
   logic [7:0]  sector;
   logic        op;
   logic [23:0] timer;
   logic        load_d;
   logic        save_d;
   logic        dl_d;

   logic idle;
   logic load_edge;
   logic save_edge;
   logic dl_rise;
   logic accept_load;
   logic accept_save;

   assign idle        = (state == S_IDLE);
   assign load_edge   = load_req & ~load_d;
   assign save_edge   = save_req & ~save_d;
   assign dl_rise     = cart_download & ~dl_d;
   assign accept_load = idle & load_edge & has_save & ~cart_download;
   // A simultaneous load edge always wins; the save edge is simply lost.
   assign accept_save = idle & save_edge & has_save & (dirty | save_force) & ~cart_download & ~accept_load;

   assign busy        = ~idle;
   assign done        = (state == S_FINISH) & ~cart_download;
   assign bk_addr     = busy ? {1'b0, sector, sd_buff_addr} : 17'd0;
   assign bk_wr       = sd_buff_wr & (state == S_XFER) & ~op;
   assign bk_data     = sd_buff_dout;
   assign sd_buff_din = bk_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         sector <= 8'd0;
         op     <= 1'b0;
         timer  <= 24'd0;
         sd_lba <= 32'd0;
         sd_rd  <= 1'b0;
         sd_wr  <= 1'b0;
         err    <= 1'b0;
         load_d <= 1'b0;
         save_d <= 1'b0;
         dl_d   <= 1'b0;
      end else begin
         load_d <= load_req;
         save_d <= save_req;
         dl_d   <= cart_download;
         // A ROM download owns the cart RAM, so any transfer in flight is dropped silently.
         if (!idle && cart_download) begin
            state <= S_IDLE;
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (accept_load || accept_save) begin
                     op     <= accept_save;
                     sector <= 8'd0;
                     err    <= 1'b0;
                     state  <= S_START;
                  end
               end
               S_START: begin
                  sd_lba <= {24'd0, sector};
                  sd_rd  <= ~op;
                  sd_wr  <= op;
                  timer  <= 24'd0;
                  state  <= S_WAIT_ACK;
               end
               S_WAIT_ACK: begin
                  if (sd_ack) begin
                     sd_rd <= 1'b0;
                     sd_wr <= 1'b0;
                     state <= S_XFER;
                  end else if (timer + 24'd1 == ACK_TIMEOUT) begin
                     sd_rd <= 1'b0;
                     sd_wr <= 1'b0;
                     err   <= 1'b1;
                     state <= S_FINISH;
                  end else begin
                     timer <= timer + 24'd1;
                  end
               end
               S_XFER: begin
                  if (!sd_ack) state <= S_NEXT;
               end
               S_NEXT: begin
                  if (sector == ram_mask_file) begin
                     state <= S_FINISH;
                  end else begin
                     sector <= sector + 8'd1;
                     state  <= S_START;
                  end
               end
               S_FINISH: state <= S_IDLE;
               default:  state <= S_IDLE;
            endcase
         end
      end
   end

   // RAM written by the CPU during a load is about to be overwritten, so it does not count as dirty.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dirty <= 1'b0;
      end else if (dl_rise || accept_save || (state == S_FINISH && !op && !cart_download)) begin
         dirty <= 1'b0;
      end else if (cram_wr && !(busy && !op)) begin
         dirty <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cart_backup_ctrl.sv
// tb/tb_cart_backup_ctrl.sv - scoreboard bench for cart_backup_ctrl with an SD host and cart RAM model
// Expected sector requests, RAM writes, host reads and done pulses are queued from a sector-level model.
module tb_cart_backup_ctrl;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        has_save;
   logic [7:0]  ram_mask_file;
   logic        cart_download;
   logic        cram_wr;
   logic        load_req;
   logic        save_req;
   logic        save_force;
   logic [31:0] sd_lba;
   logic        sd_rd;
   logic        sd_wr;
   logic        sd_ack;
   logic [7:0]  sd_buff_addr;
   logic [15:0] sd_buff_dout;
   logic        sd_buff_wr;
   logic [15:0] sd_buff_din;
   logic [16:0] bk_addr;
   logic        bk_wr;
   logic [15:0] bk_data;
   logic [15:0] bk_q;
   logic        busy;
   logic        done;
   logic        err;
   logic        dirty;

   int vectors     = 0;
   int miscompares = 0;

   bit          ack_en     = 1'b1;
   bit          host_abort = 1'b0;
   bit          chk_wr     = 1'b1;
   bit          mem_init   = 1'b0;
   logic [15:0] img_seed   = 16'd0;
   logic [7:0]  h_lba      = 8'd0;
   logic [15:0] mem     [0:4095];
   logic [15:0] ref_mem [0:4095];
   logic        prv_rd = 1'b0;
   logic        prv_wr = 1'b0;

   int       req_q[$];
   bit [32:0] wr_q[$];
   bit [15:0] rd_q[$];
   bit       done_q[$];

   cart_backup_ctrl #(.ACK_TIMEOUT(24'd100)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .has_save(has_save), .ram_mask_file(ram_mask_file),
      .cart_download(cart_download), .cram_wr(cram_wr), .load_req(load_req), .save_req(save_req),
      .save_force(save_force), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
      .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
      .sd_buff_din(sd_buff_din), .bk_addr(bk_addr), .bk_wr(bk_wr), .bk_data(bk_data), .bk_q(bk_q),
      .busy(busy), .done(done), .err(err), .dirty(dirty)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) begin
      if (mem_init) begin
         for (int a = 0; a < 4096; a++) mem[a] <= 16'(a) ^ 16'h5A5A;
      end else if (bk_wr) begin
         mem[bk_addr[11:0]] <= bk_data;
      end
      bk_q <= mem[bk_addr[11:0]];
   end

   function automatic logic [15:0] img(input logic [15:0] seed, input int s, input int i);
      return 16'(int'(seed) + s * 977 + i * 31);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic pulse(input bit ld, input bit sv);
      @(posedge clk_sys); #1;
      load_req = ld;
      save_req = sv;
      wait_cycles(2);
      load_req = 1'b0;
      save_req = 1'b0;
   endtask

   task automatic cram_pulse();
      @(posedge clk_sys); #1;
      cram_wr = 1'b1;
      @(posedge clk_sys); #1;
      cram_wr = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int n = 0; n < 20000; n++) begin
         if (!busy) break;
         @(negedge clk_sys);
      end
      check({name, "_idle"}, busy, 0);
   endtask

   task automatic expect_load(input logic [7:0] m);
      for (int s = 0; s <= int'(m); s++) begin
         req_q.push_back(s);
         for (int i = 0; i < 256; i++) begin
            ref_mem[s * 256 + i] = img(img_seed, s, i);
            wr_q.push_back({17'(s * 256 + i), img(img_seed, s, i)});
         end
      end
      done_q.push_back(1'b0);
   endtask

   task automatic expect_save(input logic [7:0] m);
      for (int s = 0; s <= int'(m); s++) begin
         req_q.push_back(256 + s);
         for (int i = 0; i < 256; i++) rd_q.push_back(ref_mem[s * 256 + i]);
      end
      done_q.push_back(1'b0);
   endtask

   // SD host: acks after a random delay, then streams one word per cycle.
   initial begin
      bit h_save;
      sd_ack       = 1'b0;
      sd_buff_wr   = 1'b0;
      sd_buff_addr = 8'd0;
      sd_buff_dout = 16'd0;
      forever begin
         @(posedge clk_sys); #1;
         if ((sd_rd || sd_wr) && ack_en && reset_n) begin
            h_lba  = sd_lba[7:0];
            h_save = sd_wr;
            repeat ($urandom_range(0, 3)) begin @(posedge clk_sys); #1; end
            sd_ack = 1'b1;
            @(posedge clk_sys); #1;
            for (int i = 0; i < 256 && !host_abort; i++) begin
               sd_buff_addr = 8'(i);
               if (!h_save) begin
                  sd_buff_dout = img(img_seed, int'(h_lba), i);
                  sd_buff_wr   = 1'b1;
               end
               @(posedge clk_sys); #1;
               if (h_save) begin
                  if (rd_q.size() == 0) check("rd_q_empty", rd_q.size(), 1);
                  else check("save_rd", sd_buff_din, rd_q.pop_front());
               end
            end
            sd_buff_wr = 1'b0;
            sd_ack     = 1'b0;
         end
      end
   end

   // Monitor: sector requests, cart RAM writes and done pulses.
   initial begin
      int e;
      bit d;
      bit [32:0] w;
      forever begin
         @(negedge clk_sys);
         if (reset_n) begin
            if ((sd_rd && !prv_rd) || (sd_wr && !prv_wr)) begin
               if (req_q.size() == 0) check("req_q_empty", req_q.size(), 1);
               else begin
                  e = req_q.pop_front();
                  check("sd_req", {sd_rd & sd_wr, sd_wr, sd_lba}, {1'b0, e[8], 24'd0, e[7:0]});
               end
            end
            if (bk_wr && chk_wr) begin
               if (wr_q.size() == 0) check("wr_q_empty", wr_q.size(), 1);
               else begin
                  w = wr_q.pop_front();
                  check("bk_write", {bk_addr, bk_data}, w);
               end
            end
            if (done) begin
               if (done_q.size() == 0) check("done_q_empty", done_q.size(), 1);
               else begin
                  d = done_q.pop_front();
                  check("done_err", err, d);
               end
            end
         end
         prv_rd = sd_rd;
         prv_wr = sd_wr;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] masks [4];
      int n;
      int sel;
      masks = '{8'h0F, 8'h03, 8'h07, 8'h01};
      reset_n = 1'b0; has_save = 1'b1; ram_mask_file = 8'h0F; cart_download = 1'b0;
      cram_wr = 1'b0; load_req = 1'b0; save_req = 1'b0; save_force = 1'b0;
      for (int a = 0; a < 4096; a++) ref_mem[a] = 16'(a) ^ 16'h5A5A;
      mem_init = 1'b1;
      wait_cycles(2);
      mem_init = 1'b0;
      check("reset_flags", {sd_rd, sd_wr, busy, done, err, dirty, bk_wr}, 0);
      check("reset_lba", sd_lba, 0);
      check("reset_bk_addr", bk_addr, 0);
      @(posedge clk_sys); #1;
      reset_n = 1'b1;

      // Full 16-sector load; CPU writes during a load must not mark the RAM dirty.
      img_seed = 16'($urandom);
      expect_load(8'h0F);
      pulse(1'b1, 1'b0);
      wait_cycles(300);
      cram_pulse();
      check("dirty_cram_in_load", dirty, 0);
      wait_idle("load0");
      check("dirty_after_load", dirty, 0);

      // Clean RAM, no force: save is refused.
      pulse(1'b0, 1'b1);
      wait_cycles(20);
      check("save_clean_busy", busy, 0);
      cram_pulse();
      check("dirty_set_idle", dirty, 1);

      // Dirty save, with CPU writes and a discarded load edge during it.
      expect_save(8'h0F);
      pulse(1'b0, 1'b1);
      check("dirty_clr_save_start", dirty, 0);
      wait_cycles(200);
      cram_pulse();
      check("dirty_cram_in_save", dirty, 1);
      pulse(1'b1, 1'b0);
      wait_idle("save0");
      wait_cycles(10);
      check("busy_edge_not_queued", busy, 0);
      check("dirty_after_save", dirty, 1);

      for (int k = 0; k < 4; k++) begin
         sel = $urandom_range(0, 2);
         ram_mask_file = masks[$urandom_range(0, 3)];
         img_seed = 16'($urandom);
         case (sel)
            0: begin expect_load(ram_mask_file); pulse(1'b1, 1'b0); end
            1: begin
               save_force = 1'b1;
               expect_save(ram_mask_file);
               pulse(1'b0, 1'b1);
               save_force = 1'b0;
            end
            default: begin
               cram_pulse();
               expect_load(ram_mask_file);
               pulse(1'b1, 1'b1);
            end
         endcase
         wait_idle("rand_op");
         check("dirty_rand_op", dirty, 0);
      end
      ram_mask_file = 8'h0F;

      // Host never acks: timeout after 100 cycles of request.
      ack_en = 1'b0;
      req_q.push_back(0);
      done_q.push_back(1'b1);
      pulse(1'b1, 1'b0);
      for (n = 0; n < 300; n++) begin
         @(negedge clk_sys);
         if (!sd_rd) break;
      end
      check("timeout_cycles", n, 100);
      wait_idle("timeout");
      check("err_after_timeout", err, 1);

      // Reset during WAIT_ACK.
      cram_pulse();
      req_q.push_back(0);
      pulse(1'b1, 1'b0);
      check("err_cleared_on_accept", err, 0);
      wait_cycles(5);
      check("wait_ack_rd", sd_rd, 1);
      reset_n = 1'b0;
      #1;
      check("midreset_flags", {sd_rd, sd_wr, busy, done, err, dirty, bk_wr}, 0);
      check("midreset_lba", sd_lba, 0);
      req_q.delete();
      done_q.delete();
      @(posedge clk_sys); #1;
      reset_n = 1'b1;
      ack_en  = 1'b1;
      img_seed = 16'($urandom);
      expect_load(8'h0F);
      pulse(1'b1, 1'b0);
      wait_idle("load_after_reset");
      check("dirty_after_reset_load", dirty, 0);

      // Requests during a ROM download are discarded.
      cart_download = 1'b1;
      pulse(1'b1, 1'b0);
      wait_cycles(5);
      check("download_blocks_req", busy, 0);
      cart_download = 1'b0;
      wait_cycles(2);

      // Download rising during the transfer of sector 3 aborts the load.
      cram_pulse();
      check("dirty_before_abort", dirty, 1);
      chk_wr = 1'b0;
      img_seed = 16'($urandom);
      for (int s = 0; s < 4; s++) req_q.push_back(s);
      pulse(1'b1, 1'b0);
      for (n = 0; n < 20000; n++) begin
         @(negedge clk_sys);
         if (sd_ack && h_lba == 8'd3) break;
      end
      check("abort_reach_sector3", n < 20000, 1);
      wait_cycles(20);
      host_abort = 1'b1;
      @(posedge clk_sys); #2;
      cart_download = 1'b1;
      @(posedge clk_sys); #1;
      check("abort_busy", busy, 0);
      check("abort_rd", sd_rd, 0);
      check("abort_dirty", dirty, 0);
      check("abort_err", err, 0);
      wait_cycles(5);
      check("abort_stays_idle", busy, 0);
      cart_download = 1'b0;
      host_abort = 1'b0;
      wait_cycles(2);
      wr_q.delete();
      chk_wr = 1'b1;

      img_seed = 16'($urandom);
      expect_load(8'h0F);
      pulse(1'b1, 1'b0);
      wait_idle("restore_load");
      wait_cycles(5);

      check("req_q_left", req_q.size(), 0);
      check("wr_q_left", wr_q.size(), 0);
      check("rd_q_left", rd_q.size(), 0);
      check("done_q_left", done_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
